// File: rtl/dip_gray_rd_unpack.sv
// Display-side gray frame reader: pops RGB565-replicated words from the SDRAM read FIFO,
// recovers 8-bit gray and emits plain or binarized RGB565 with position and frame markers.
module dip_gray_rd_unpack #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_req,
    input  logic        disp_mode,
    input  logic [7:0]  bin_thresh,
    input  logic        rd_fifo_empty,
    input  logic [15:0] sdram_rd_data,
    output logic        sdram_rd_en,
    output logic [15:0] vga_rgb,
    output logic [7:0]  gray_data,
    output logic        pix_valid,
    output logic [9:0]  x_cnt,
    output logic [9:0]  y_cnt,
    output logic        line_done,
    output logic        frame_done,
    output logic        underflow
);

    localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [9:0]  x_r;
    logic [9:0]  y_r;
    logic        s1_vld_r;
    logic        s1_empty_r;
    logic [9:0]  s1_x_r;
    logic [9:0]  s1_y_r;
    logic        take_s;
    logic        rd_en_s;
    logic [7:0]  gray_s;
    logic [15:0] rgb_s;
    logic        rd_data_unused_s;

    // The stored word replicates gray into all three fields; green carries the most bits.
    function automatic logic [7:0] gray_from_word(input logic [15:0] w);
        return {w[10:5], w[10:9]};
    endfunction

    function automatic logic [15:0] rgb_from_gray(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    assign rd_data_unused_s = ^{sdram_rd_data[15:11], sdram_rd_data[4:0]};

    // Request acceptance and FIFO pop decode from registered state.
    always_comb begin
        take_s  = 1'b0;
        rd_en_s = 1'b0;
        if (pix_req && (state_r == ST_ACTIVE)) begin
            take_s  = 1'b1;
            rd_en_s = ~rd_fifo_empty;
        end else begin
            take_s  = 1'b0;
            rd_en_s = 1'b0;
        end
    end

    assign sdram_rd_en = rd_en_s;

    // Gray recovery and display formatting on the captured word; an underflowed slot shows black.
    always_comb begin
        gray_s = 8'h00;
        rgb_s  = 16'h0000;
        if (s1_empty_r) begin
            gray_s = 8'h00;
        end else begin
            gray_s = gray_from_word(sdram_rd_data);
        end
        if (disp_mode) begin
            rgb_s = (gray_s >= bin_thresh) ? 16'hFFFF : 16'h0000;
        end else begin
            rgb_s = rgb_from_gray(gray_s);
        end
    end

    // Frame state and request position counters.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            x_r     <= 10'd0;
            y_r     <= 10'd0;
        end else if (frame_start) begin
            state_r <= ST_ACTIVE;
            x_r     <= 10'd0;
            y_r     <= 10'd0;
        end else if (take_s) begin
            if (x_r == X_LAST) begin
                x_r <= 10'd0;
                if (y_r == Y_LAST) begin
                    y_r     <= 10'd0;
                    state_r <= ST_DONE;
                end else begin
                    y_r <= y_r + 10'd1;
                end
            end else begin
                x_r <= x_r + 10'd1;
            end
        end
    end

    // S1 slot: remembers whether a pixel was taken, its position and whether the pop was skipped.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r   <= 1'b0;
            s1_empty_r <= 1'b0;
            s1_x_r     <= 10'd0;
            s1_y_r     <= 10'd0;
        end else begin
            s1_vld_r   <= take_s;
            s1_empty_r <= take_s & rd_fifo_empty;
            s1_x_r     <= x_r;
            s1_y_r     <= y_r;
        end
    end

    // S2 output registers; pixel data and position hold between valid slots.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            vga_rgb    <= 16'h0000;
            gray_data  <= 8'h00;
            x_cnt      <= 10'd0;
            y_cnt      <= 10'd0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= s1_vld_r;
            line_done  <= s1_vld_r && (s1_x_r == X_LAST);
            frame_done <= s1_vld_r && (s1_x_r == X_LAST) && (s1_y_r == Y_LAST);
            if (s1_vld_r) begin
                vga_rgb   <= rgb_s;
                gray_data <= gray_s;
                x_cnt     <= s1_x_r;
                y_cnt     <= s1_y_r;
            end
        end
    end

    // Sticky underflow, cleared when a new frame begins.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (frame_start) begin
            underflow <= 1'b0;
        end else if (s1_vld_r && s1_empty_r) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dip_gray_rd_unpack.sv
// Table-driven bench for dip_gray_rd_unpack on a small 8x2 frame, plus a hand-written reset sequence.
module tb_dip_gray_rd_unpack;

    localparam int H = 8;
    localparam int V = 2;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_req;
    logic        disp_mode;
    logic [7:0]  bin_thresh;
    logic        rd_fifo_empty;
    logic [15:0] sdram_rd_data;
    logic        sdram_rd_en;
    logic [15:0] vga_rgb;
    logic [7:0]  gray_data;
    logic        pix_valid;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic        line_done;
    logic        frame_done;
    logic        underflow;

    dip_gray_rd_unpack #(.H_ACT(H), .V_ACT(V)) dut (
        .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .pix_req(pix_req),
        .disp_mode(disp_mode), .bin_thresh(bin_thresh), .rd_fifo_empty(rd_fifo_empty),
        .sdram_rd_data(sdram_rd_data), .sdram_rd_en(sdram_rd_en), .vga_rgb(vga_rgb),
        .gray_data(gray_data), .pix_valid(pix_valid), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .line_done(line_done), .frame_done(frame_done), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        fs;
        logic        req;
        logic        empty;
        logic [15:0] data;
        logic        mode;
        logic [7:0]  thresh;
        logic [15:0] exp_rgb;
        logic [7:0]  exp_gray;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state carried across segments
    bit          m_active = 1'b0;
    int          mx = 0;
    int          my = 0;
    logic        m_uf = 1'b0;
    logic [15:0] last_rgb = 16'h0000;
    logic [7:0]  last_gray = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic fs, input logic req, input logic empty, input logic [15:0] data,
                       input logic mode, input logic [7:0] thr, input logic [15:0] rgb,
                       input logic [7:0] gray);
        vec_t v;
        v.fs = fs; v.req = req; v.empty = empty; v.data = data;
        v.mode = mode; v.thresh = thr; v.exp_rgb = rgb; v.exp_gray = gray;
        vecs.push_back(v);
    endtask

    task automatic add_px(input logic [15:0] data, input logic mode, input logic [7:0] thr,
                          input logic [15:0] rgb, input logic [7:0] gray);
        add(1'b0, 1'b1, 1'b0, data, mode, thr, rgb, gray);
    endtask

    task automatic add_fs();
        add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
    endtask

    task automatic add_idle();
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
    endtask

    // Applies vecs[first +: n] one per cycle and checks every output slot against the model.
    task automatic run_stream(input int first, input int n);
        bit          pv[64];
        logic [15:0] prgb[64];
        logic [7:0]  pgray[64];
        int          px[64];
        int          py[64];
        bit          pset[64];
        bit          pclr[64];
        vec_t        v;
        vec_t        vp;
        bit          exp_en;
        for (int i = 0; i < 64; i++) begin
            pv[i] = 1'b0; pset[i] = 1'b0; pclr[i] = 1'b0;
            prgb[i] = 16'h0000; pgray[i] = 8'h00; px[i] = 0; py[i] = 0;
        end
        for (int c = 0; c < n + 2; c++) begin
            @(negedge pclk);
            if (pclr[c]) m_uf = 1'b0;
            else if (pset[c]) m_uf = 1'b1;
            chk("pix_valid", 32'(pix_valid), 32'(pv[c]));
            if (pv[c]) begin
                last_rgb  = prgb[c];
                last_gray = pgray[c];
                chk("x_cnt", 32'(x_cnt), 32'(px[c]));
                chk("y_cnt", 32'(y_cnt), 32'(py[c]));
                chk("line_done", 32'(line_done), 32'(px[c] == H - 1));
                chk("frame_done", 32'(frame_done), 32'((px[c] == H - 1) && (py[c] == V - 1)));
            end else begin
                chk("line_done_idle", 32'(line_done), 32'd0);
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
            chk("vga_rgb", 32'(vga_rgb), 32'(last_rgb));
            chk("gray_data", 32'(gray_data), 32'(last_gray));
            chk("underflow", 32'(underflow), 32'(m_uf));

            if (c < n) begin
                v = vecs[first + c];
            end else begin
                v.fs = 1'b0; v.req = 1'b0; v.empty = 1'b0;
            end
            frame_start   = v.fs;
            pix_req       = v.req;
            rd_fifo_empty = v.empty;
            if (c >= 1 && c - 1 < n) begin
                vp            = vecs[first + c - 1];
                sdram_rd_data = vp.empty ? 16'h1234 : vp.data;
                disp_mode     = vp.mode;
                bin_thresh    = vp.thresh;
            end else begin
                sdram_rd_data = 16'h0000;
            end
            #1;
            exp_en = (c < n) && v.req && m_active && !v.empty;
            chk("sdram_rd_en", 32'(sdram_rd_en), 32'(exp_en));

            if (c < n) begin
                if (v.fs) begin
                    pclr[c + 1] = 1'b1;
                    m_active = 1'b1;
                    mx = 0;
                    my = 0;
                end else if (v.req && m_active) begin
                    pv[c + 2]    = 1'b1;
                    prgb[c + 2]  = v.exp_rgb;
                    pgray[c + 2] = v.exp_gray;
                    px[c + 2]    = mx;
                    py[c + 2]    = my;
                    if (v.empty) pset[c + 2] = 1'b1;
                    if (mx == H - 1) begin
                        mx = 0;
                        if (my == V - 1) begin
                            my = 0;
                            m_active = 1'b0;
                        end else begin
                            my = my + 1;
                        end
                    end else begin
                        mx = mx + 1;
                    end
                end
            end
        end
        frame_start = 1'b0;
        pix_req     = 1'b0;
    endtask

    int sa, sb, sc, sd, se, sf;

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_req = 1'b1; disp_mode = 1'b0;
        bin_thresh = 8'h00; rd_fifo_empty = 1'b0; sdram_rd_data = 16'h0000;
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_vga_rgb", 32'(vga_rgb), 32'd0);
        chk("rst_gray", 32'(gray_data), 32'd0);
        chk("rst_xy", 32'({x_cnt, y_cnt}), 32'd0);
        chk("rst_done", 32'({line_done, frame_done, underflow}), 32'd0);
        chk("rst_rd_en", 32'(sdram_rd_en), 32'd0);
        pix_req = 1'b0;
        rst_n = 1'b1;

        // Requests before any frame_start are ignored
        sa = vecs.size();
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        // Gray and binarized decode, threshold equality, per-pixel mode change
        sb = vecs.size();
        add_fs();
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        add_px(16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
        add_px(16'h8410, 1'b0, 8'h00, 16'h8410, 8'h82);
        add_px(16'h7BEF, 1'b0, 8'h00, 16'h7BEF, 8'h7D);
        add_px(16'h8410, 1'b1, 8'h80, 16'hFFFF, 8'h82);
        add_px(16'h7BEF, 1'b1, 8'h80, 16'h0000, 8'h7D);
        add_px(16'h8410, 1'b1, 8'h82, 16'hFFFF, 8'h82);
        add_px(16'h7BEF, 1'b1, 8'h7D, 16'hFFFF, 8'h7D);
        add_px(16'h7BEF, 1'b1, 8'h7E, 16'h0000, 8'h7D);
        // Full 8x2 frame with two surplus requests after the last pixel
        sc = vecs.size();
        add_fs();
        for (int i = 0; i < 18; i++) begin
            if (i % 2 == 0) add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
            else            add_px(16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
        end
        // Underflow on the third request, sticky until the next frame_start
        sd = vecs.size();
        add_fs();
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        add_px(16'h8410, 1'b0, 8'h00, 16'h8410, 8'h82);
        add(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
        add_px(16'h7BEF, 1'b0, 8'h00, 16'h7BEF, 8'h7D);
        se = vecs.size();
        add_idle();
        add_idle();
        add_idle();
        add_fs();
        add_idle();
        // Mid-frame restart with two pixels still in flight
        sf = vecs.size();
        add_fs();
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        add_px(16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);
        add_px(16'h8410, 1'b0, 8'h00, 16'h8410, 8'h82);
        add_px(16'h7BEF, 1'b0, 8'h00, 16'h7BEF, 8'h7D);
        add_px(16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 8'hFF);
        add_fs();
        add_px(16'h8410, 1'b0, 8'h00, 16'h8410, 8'h82);
        add_px(16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00);

        run_stream(sa, sb - sa);
        run_stream(sb, sc - sb);
        run_stream(sc, sd - sc);
        run_stream(sd, se - sd);
        run_stream(se, sf - se);
        run_stream(sf, vecs.size() - sf);

        // Asynchronous reset while streaming
        @(negedge pclk);
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0; pix_req = 1'b1; rd_fifo_empty = 1'b0; disp_mode = 1'b0;
        sdram_rd_data = 16'hFFFF;
        repeat (3) @(negedge pclk);
        chk("stream_valid", 32'(pix_valid), 32'd1);
        chk("stream_rgb", 32'(vga_rgb), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        chk("arst_pix_valid", 32'(pix_valid), 32'd0);
        chk("arst_rgb", 32'(vga_rgb), 32'd0);
        chk("arst_gray", 32'(gray_data), 32'd0);
        chk("arst_xy", 32'({x_cnt, y_cnt}), 32'd0);
        chk("arst_rd_en", 32'(sdram_rd_en), 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("post_rst_rd_en", 32'(sdram_rd_en), 32'd0);
            chk("post_rst_valid", 32'(pix_valid), 32'd0);
        end
        pix_req = 1'b0;
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
        pix_req = 1'b1;
        #1;
        chk("restart_rd_en", 32'(sdram_rd_en), 32'd1);
        @(negedge pclk);
        pix_req = 1'b0;
        @(negedge pclk);
        chk("restart_valid", 32'(pix_valid), 32'd1);
        chk("restart_rgb", 32'(vga_rgb), 32'hFFFF);
        chk("restart_xy", 32'({x_cnt, y_cnt}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
